// File: rtl/irq_pkg.sv
// Shared constants and state encoding for the interrupt pending controller.
package irq_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    ST_IDLE,
    ST_PRESENT
  } state_e;

endpackage

// File: rtl/prio_enc_valid.sv
// Combinational highest-index priority encoder with an any-valid flag.
module prio_enc_valid
  import irq_pkg::*;
#(
  parameter int unsigned W  = N,
  parameter int unsigned IW = IDX_W
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx_c,
  output logic          any_valid_c
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx_c       = '0;
    any_valid_c = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      if (vec[i]) begin
        idx_c       = IW'(i);
        any_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Edge-captures request lines into a pending register and presents the
// highest-priority unmasked pending index on a valid/ready handshake.
module irq_pending_ctrl
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             irq_ready,
  input  logic             clr_lost,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     lost
);

  state_e           state;
  state_e           state_nxt;
  logic [N-1:0]     req_q;
  logic [N-1:0]     rise;
  logic [N-1:0]     clr;
  logic             acc;
  logic [N-1:0]     pending_nxt;
  logic [N-1:0]     lost_nxt;
  logic             valid_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

  // Encoder only matters in IDLE; the presented index is frozen in PRESENT.
  prio_enc_valid #(
    .W  (N),
    .IW (IDX_W)
  ) u_enc (
    .vec         (pending & mask),
    .idx_c       (enc_idx),
    .any_valid_c (enc_any)
  );

  // Event detection, acceptance clear, and next pending/lost values.
  always_comb begin
    rise        = req_in & ~req_q;
    acc         = irq_valid & irq_ready;
    clr         = acc ? (N'(1) << irq_idx) : '0;
    pending_nxt = (pending & ~clr) | rise;
    lost_nxt    = (clr_lost ? '0 : lost) | (rise & pending & ~clr);
  end

  // Next-state and next registered outputs of the presentation FSM.
  always_comb begin
    state_nxt = state;
    valid_nxt = irq_valid;
    idx_nxt   = irq_idx;
    case (state)
      ST_IDLE: begin
        valid_nxt = 1'b0;
        if (enc_any) begin
          valid_nxt = 1'b1;
          idx_nxt   = enc_idx;
          state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        valid_nxt = 1'b1;
        if (acc) begin
          valid_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      pending   <= '0;
      lost      <= '0;
      irq_valid <= 1'b0;
      irq_idx   <= '0;
    end else begin
      state     <= state_nxt;
      req_q     <= req_in;
      pending   <= pending_nxt;
      lost      <= lost_nxt;
      irq_valid <= valid_nxt;
      irq_idx   <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench: expected indices are queued at stimulus time and
// popped when the DUT completes a handshake; state checks are direct.
module tb_irq_pending_ctrl;
  import irq_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_in;
  logic [N-1:0]     mask;
  logic             irq_ready;
  logic             clr_lost;
  logic             irq_valid;
  logic [IDX_W-1:0] irq_idx;
  logic [N-1:0]     pending;
  logic [N-1:0]     lost;

  int vectors;
  int miscompares;
  logic [IDX_W-1:0] exp_q[$];

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .irq_ready (irq_ready),
    .clr_lost  (clr_lost),
    .irq_valid (irq_valid),
    .irq_idx   (irq_idx),
    .pending   (pending),
    .lost      (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain", 32'(exp_q.size()), 0);
  endtask

  // Handshake monitor: inputs are stable mid-cycle, so a valid&ready seen
  // at the falling edge is accepted at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && irq_valid && irq_ready) begin
      chk("acc_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("acc_idx", 32'(irq_idx), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_in      = '0;
    mask        = '0;
    irq_ready   = 1'b0;
    clr_lost    = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Build a busy state, then reset mid-cycle.
    mask   = 8'hFF;
    req_in = 8'hFF;
    step();
    req_in = '0;
    step();
    chk("pre_rst_pending", 32'(pending), 32'h FF);
    chk("pre_rst_valid", 32'(irq_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pending", 32'(pending), 0);
    chk("rst_valid", 32'(irq_valid), 0);
    chk("rst_idx", 32'(irq_idx), 0);
    chk("rst_lost", 32'(lost), 0);
    step();
    rst_n = 1'b1;
    step();

    // Single event on line 3.
    irq_ready = 1'b1;
    exp_q.push_back(3'd3);
    req_in = 8'h08;
    step();
    chk("single_pending", 32'(pending), 32'h08);
    chk("single_valid_e0", 32'(irq_valid), 0);
    req_in = '0;
    step();
    chk("single_valid_e1", 32'(irq_valid), 1);
    chk("single_idx", 32'(irq_idx), 3);
    step();
    chk("single_pending_clr", 32'(pending), 0);
    chk("single_valid_clr", 32'(irq_valid), 0);

    // Priority order with one bubble between windows.
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd0);
    req_in = 8'hA5;
    step();
    req_in = '0;
    chk("prio_pending", 32'(pending), 32'hA5);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("prio_valid", 32'(irq_valid), 32'((i % 2) == 0));
    end
    chk("prio_pending_end", 32'(pending), 0);
    chk("prio_q", 32'(exp_q.size()), 0);

    // Hold under backpressure; no preemption, masking does not withdraw.
    irq_ready = 1'b0;
    req_in    = 8'h04;
    step();
    req_in = '0;
    step();
    chk("hold_valid0", 32'(irq_valid), 1);
    chk("hold_idx0", 32'(irq_idx), 2);
    req_in = 8'h40;
    mask   = 8'hFB;
    step();
    req_in = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", 32'(irq_valid), 1);
      chk("hold_idx", 32'(irq_idx), 2);
    end
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd6);
    irq_ready = 1'b1;
    wait_drain(10);
    step();
    chk("hold_valid_end", 32'(irq_valid), 0);
    chk("hold_pending_end", 32'(pending), 0);
    mask = 8'hFF;

    // Lost flag on a repeat event, then clr_lost.
    irq_ready = 1'b0;
    req_in    = 8'h10;
    step();
    req_in = '0;
    step();
    chk("lost_before", 32'(lost), 0);
    req_in = 8'h10;
    step();
    req_in = '0;
    chk("lost_set", 32'(lost), 32'h10);
    chk("lost_idx", 32'(irq_idx), 4);
    clr_lost = 1'b1;
    step();
    clr_lost = 1'b0;
    chk("lost_clr", 32'(lost), 0);

    // New event on 4 coincides with acceptance of 4.
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd4);
    irq_ready = 1'b1;
    req_in    = 8'h10;
    step();
    req_in = '0;
    chk("coin_pending", 32'(pending), 32'h10);
    chk("coin_lost", 32'(lost), 0);
    chk("coin_valid", 32'(irq_valid), 0);
    wait_drain(10);
    step();
    chk("coin_pending_end", 32'(pending), 0);
    chk("coin_lost_end", 32'(lost), 0);

    // Masked lines capture but are not presented until unmasked.
    mask   = 8'h00;
    req_in = 8'h82;
    step();
    req_in = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mask_valid_off", 32'(irq_valid), 0);
      chk("mask_pending", 32'(pending), 32'h82);
    end
    exp_q.push_back(3'd1);
    mask = 8'h02;
    n    = 0;
    while (!irq_valid && n < 4) begin
      step();
      n++;
    end
    chk("mask_valid_on", 32'(irq_valid), 1);
    chk("mask_idx", 32'(irq_idx), 1);
    wait_drain(10);
    step();
    chk("mask_pending_end", 32'(pending), 32'h80);
    chk("mask_valid_end", 32'(irq_valid), 0);

    chk("q_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
